dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port, byte-addressed, big-endian data memory between the CPU load/store path (port 0) and a loader/debug master (port 1). It serialises word accesses, drives the memory's read/write strobes for exactly one cycle per transaction, and returns read data and a one-cycle acknowledge to the winning requester. It also produces the CPU stall signal while a port-0 access is outstanding.

## Interface
- ADDR_W, 32, address width of both requester ports and of the memory port
- DATA_W, 32, data width; fixed word size, 4 bytes per access

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request; held high until the matching ack
- we0 / we1  in  1  1 = store, 0 = load; held stable while req high
- addr0 / addr1  in  ADDR_W  byte address; held stable while req high
- wdata0 / wdata1  in  DATA_W  store data; held stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  one-cycle pulse coincident with ack when the access was misaligned
- rdata0 / rdata1  out  DATA_W  load data; valid in the ack cycle, held until the next ack on that port
- cpu_stall  out  1  combinational: req0 & ~ack0
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid by the end of the mem_read cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, select a winner, latch its we/addr/wdata and port id, then go to ACCESS (or RESP directly if addr[1:0] != 0). Otherwise stay in IDLE.
- ACCESS: mem_read = ~we or mem_write = we, held for exactly this one cycle, with mem_addr/mem_wdata taken from the latched values. On exit, a load captures mem_rdata into the winner's rdata register. Go to RESP.
- RESP: ack of the winner is high for one cycle and the FSM returns to IDLE. The requester must drop req at the edge that ends RESP; a req still high in IDLE is a new request.
- Misaligned access (addr[1:0] != 0): no memory strobe; RESP is reached with err high; rdata of that port is set to 0.
- Losing requester: its req stays pending and is evaluated again in the next IDLE cycle. Its ack stays low.
- The non-winning port's rdata is never modified.
- Outputs are registered except cpu_stall. mem_addr and mem_wdata are 0 whenever the FSM is not in ACCESS.

## Timing
- Reset values: state = IDLE, every ack/err = 0, every rdata = 0, mem_read = mem_write = 0, mem_addr = mem_wdata = 0, last_grant = 1.
- An asserted reset deasserts mem strobes immediately (asynchronously). An in-flight write aborted this way is not performed and gets no ack.
- Aligned access: req is seen in IDLE at cycle N, ACCESS is cycle N+1, ack is cycle N+2. Back-to-back throughput is one access per 3 cycles.
- Misaligned access: ack/err is at cycle N+1.
- Simultaneous req0 and req1 in IDLE: the winner is set by the arbitration policy (see Configuration), and the loser is served starting in the next IDLE cycle.
- A req that rises during ACCESS or RESP is not sampled until IDLE.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined: a last_grant register toggles priority. On simultaneous requests, the port not granted last wins. last_grant updates on every grant.
- Undefined: fixed priority, so port 0 (CPU) always wins ties. The last_grant register is not built.

## Test plan
- Reset then single load on port 0 at addr 0x0 with memory word 0x00000005: mem_read high for one cycle, ack0 two cycles after req, rdata0 = 0x00000005, cpu_stall high for exactly 2 cycles.
- Store on port 1 to 0x10 with wdata1 = 0xDEADBEEF, then load on port 0 from 0x10: single-cycle mem_write with mem_addr 0x10, then rdata0 = 0xDEADBEEF.
- req0 and req1 rise together, repeated 4 times: with the macro, grants are 0,1,0,1… and no port starves; without it, port 0 is served first in every tie.
- Misaligned load at addr1 = 0x6: no mem strobe, ack1 and err1 one cycle after req, rdata1 = 0.
- reset pulsed during ACCESS of a store to 0x20: mem_write drops asynchronously, memory at 0x20 is unchanged, no ack, and all outputs return to reset values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, byte-addressed, big-endian data memory
// between the CPU load/store path (port 0) and a loader/debug master (port 1).
// Each word access takes IDLE -> ACCESS -> RESP, with a one-cycle memory strobe
// and a one-cycle ack. A misaligned access skips the memory entirely.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (round-robin tie breaking).
// When the macro is undefined, port 0 always wins ties.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic              cpu_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    logic              lat_port;
    logic              lat_we;
    logic              grant_valid;
    logic              grant_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_mis;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Pick the winner: on a tie the port that was not granted last goes first.
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = (req0 & req1) ? ~last_grant : req1;
    end

    // Remember which port received the most recent grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant_port;
        end
    end
`else
    // Pick the winner: the CPU port always wins a tie.
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = ~req0 & req1;
    end
`endif

    // Route the winning port's request fields and flag a non-word-aligned address.
    always_comb begin
        sel_we    = grant_port ? we1    : we0;
        sel_addr  = grant_port ? addr1  : addr0;
        sel_wdata = grant_port ? wdata1 : wdata0;
        sel_mis   = (sel_addr[1:0] != 2'b00);
    end

    // The CPU is stalled from the moment it requests until its ack cycle.
    assign cpu_stall = req0 & ~ack0;

    // Main FSM with registered strobes, acks, errors and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_port <= grant_port;
                        lat_we   <= sel_we;
                        if (sel_mis) begin
                            state <= RESP;
                            if (grant_port) begin
                                ack1   <= 1'b1;
                                err1   <= 1'b1;
                                rdata1 <= '0;
                            end else begin
                                ack0   <= 1'b1;
                                err0   <= 1'b1;
                                rdata0 <= '0;
                            end
                        end else begin
                            state     <= ACCESS;
                            mem_read  <= ~sel_we;
                            mem_write <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (lat_port) begin
                        ack1 <= 1'b1;
                        if (!lat_we) begin
                            rdata1 <= mem_rdata;
                        end
                    end else begin
                        ack0 <= 1'b1;
                        if (!lat_we) begin
                            rdata0 <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a word memory model
// and a scoreboard of expected acknowledgements.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic        cpu_stall, mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] model_rd [2];
    logic        model_last;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .cpu_stall(cpu_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] = mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_read) rd_cycles++;
        if (mem_write) begin
            wr_cycles++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        drive(p, we, a, d);
        e.port = p[0];
        e.err  = (a[1:0] != 2'b00);
        if (e.err) model_rd[p] = '0;
        else if (!we) model_rd[p] = ref_mem[a[7:2]];
        else ref_mem[a[7:2]] = d;
        e.rdata = model_rd[p];
        model_last = p[0];
        exp_q.push_back(e);
    endtask

    function automatic int tie_winner();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        return model_last ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    task automatic wait_ack(input int budget, output int port, output int cycles);
        port = -1;
        cycles = 0;
        while (port < 0 && cycles < budget) begin
            step();
            cycles++;
            if (ack0) port = 0;
            else if (ack1) port = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        step();
        step();
        n_checks++;
        if ({ack0, ack1, err0, err1, mem_read, mem_write, cpu_stall} !== 7'b0)
            $display("[TB] FAIL reset_flags: got %b want 0000000",
                     {ack0, ack1, err0, err1, mem_read, mem_write, cpu_stall});
        else n_pass++;
        n_checks++;
        if ({rdata0, rdata1} !== 64'h0)
            $display("[TB] FAIL reset_rdata: got %h %h want 0 0", rdata0, rdata1);
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata} !== 64'h0)
            $display("[TB] FAIL reset_membus: got %h %h want 0 0", mem_addr, mem_wdata);
        else n_pass++;
        reset = 1'b0;
        model_last = 1'b1;
        model_rd[0] = '0;
        model_rd[1] = '0;
        step();
    endtask

    task automatic test_single_load();
        int   rd0;
        exp_t e;
        rd0 = rd_cycles;
        issue(0, 1'b0, 32'h0, 32'h0);
        #1;
        n_checks++;
        if (cpu_stall !== 1'b1) $display("[TB] FAIL stall_c0: got %b want 1", cpu_stall);
        else n_pass++;
        step();
        n_checks++;
        if ({mem_read, mem_write, ack0, cpu_stall} !== 4'b1001)
            $display("[TB] FAIL access_cycle: got rd/wr/ack/stall %b want 1001",
                     {mem_read, mem_write, ack0, cpu_stall});
        else n_pass++;
        n_checks++;
        if (mem_addr !== 32'h0) $display("[TB] FAIL load_addr: got %h want 0", mem_addr);
        else n_pass++;
        step();
        n_checks++;
        if ({ack0, cpu_stall, mem_read} !== 3'b100)
            $display("[TB] FAIL resp_cycle: got ack/stall/rd %b want 100", {ack0, cpu_stall, mem_read});
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL load_sb: ack seen with empty scoreboard");
        else begin
            e = exp_q.pop_front();
            if ({err0, rdata0} !== {e.err, e.rdata})
                $display("[TB] FAIL load_data: got err=%b rdata=%h want err=%b rdata=%h",
                         err0, rdata0, e.err, e.rdata);
            else n_pass++;
        end
        req0 = 1'b0;
        step();
        n_checks++;
        if ({ack0, rdata0} !== {1'b0, 32'h5})
            $display("[TB] FAIL load_hold: got ack=%b rdata=%h want ack=0 rdata=00000005", ack0, rdata0);
        else n_pass++;
        n_checks++;
        if (rd_cycles - rd0 !== 1) $display("[TB] FAIL load_strobe_len: got %0d want 1", rd_cycles - rd0);
        else n_pass++;
    endtask

    task automatic test_store_then_load();
        int   wr0, p, c;
        exp_t e;
        logic [33:0] got, want;
        wr0 = wr_cycles;
        issue(1, 1'b1, 32'h10, 32'hDEADBEEF);
        wait_ack(10, p, c);
        n_checks++;
        if (p < 0 || exp_q.size() == 0) $display("[TB] FAIL store_ack: got none want ack1");
        else begin
            e = exp_q.pop_front();
            got  = {p[0], (p == 1) ? err1 : err0, (p == 1) ? rdata1 : rdata0};
            want = {e.port, e.err, e.rdata};
            if (got !== want || c != 2) $display("[TB] FAIL store_ack: got %h at %0d want %h at 2", got, c, want);
            else n_pass++;
        end
        req1 = 1'b0;
        n_checks++;
        if ({wr_cycles - wr0, last_waddr, last_wdata} !== {32'd1, 32'h10, 32'hDEADBEEF})
            $display("[TB] FAIL store_bus: got n=%0d addr=%h data=%h want n=1 addr=10 data=deadbeef",
                     wr_cycles - wr0, last_waddr, last_wdata);
        else n_pass++;
        n_checks++;
        if (rdata0 !== 32'h5) $display("[TB] FAIL store_other_rdata: got %h want 00000005", rdata0);
        else n_pass++;
        step();
        issue(0, 1'b0, 32'h10, 32'h0);
        wait_ack(10, p, c);
        n_checks++;
        if (p < 0 || exp_q.size() == 0) $display("[TB] FAIL reload_ack: got none want ack0");
        else begin
            e = exp_q.pop_front();
            got  = {p[0], (p == 1) ? err1 : err0, (p == 1) ? rdata1 : rdata0};
            want = {e.port, e.err, e.rdata};
            if (got !== want || rdata0 !== 32'hDEADBEEF)
                $display("[TB] FAIL reload_data: got %h want %h", got, want);
            else n_pass++;
        end
        req0 = 1'b0;
        step();
    endtask

    task automatic test_arbitration();
        int   w, p, c;
        exp_t e;
        logic [33:0] got, want;
        for (int r = 0; r < 4; r++) begin
            mem[16] = 32'h11110000 + r; ref_mem[16] = 32'h11110000 + r;
            mem[17] = 32'h22220000 + r; ref_mem[17] = 32'h22220000 + r;
            w = tie_winner();
            issue(w, 1'b0, (w == 0) ? 32'h40 : 32'h44, 32'h0);
            issue(1 - w, 1'b0, (w == 0) ? 32'h44 : 32'h40, 32'h0);
            for (int k = 0; k < 2; k++) begin
                wait_ack(12, p, c);
                n_checks++;
                if (p < 0 || exp_q.size() == 0) $display("[TB] FAIL tie_r%0d_k%0d: no ack", r, k);
                else begin
                    e = exp_q.pop_front();
                    got  = {p[0], (p == 1) ? err1 : err0, (p == 1) ? rdata1 : rdata0};
                    want = {e.port, e.err, e.rdata};
                    if (got !== want) $display("[TB] FAIL tie_r%0d_k%0d: got %h want %h", r, k, got, want);
                    else n_pass++;
                    n_checks++;
                    if (c != 2 + k) $display("[TB] FAIL tie_lat_r%0d_k%0d: got %0d want %0d", r, k, c, 2 + k);
                    else n_pass++;
                    if (p == 0) req0 = 1'b0;
                    else req1 = 1'b0;
                end
            end
            req0 = 1'b0;
            req1 = 1'b0;
            step();
        end
    endtask

    task automatic test_misaligned();
        int   rd0, wr0, p, c;
        exp_t e;
        logic [31:0] keep0;
        rd0 = rd_cycles;
        wr0 = wr_cycles;
        keep0 = rdata0;
        issue(1, 1'b0, 32'h6, 32'h0);
        wait_ack(10, p, c);
        n_checks++;
        if (p < 0 || exp_q.size() == 0) $display("[TB] FAIL mis_load_ack: no ack");
        else begin
            e = exp_q.pop_front();
            if ({p[0], err1, rdata1} !== {e.port, e.err, e.rdata} || c != 1)
                $display("[TB] FAIL mis_load: got port=%0d err=%b rdata=%h at %0d want port=1 err=1 rdata=0 at 1",
                         p, err1, rdata1, c);
            else n_pass++;
        end
        n_checks++;
        if (rdata0 !== keep0) $display("[TB] FAIL mis_other_rdata: got %h want %h", rdata0, keep0);
        else n_pass++;
        req1 = 1'b0;
        step();
        n_checks++;
        if (err1 !== 1'b0) $display("[TB] FAIL mis_err_pulse: got %b want 0", err1);
        else n_pass++;
        issue(0, 1'b1, 32'h13, 32'h55AA55AA);
        wait_ack(10, p, c);
        n_checks++;
        if (p < 0 || exp_q.size() == 0) $display("[TB] FAIL mis_store_ack: no ack");
        else begin
            e = exp_q.pop_front();
            if ({p[0], err0, rdata0} !== {e.port, e.err, e.rdata} || c != 1)
                $display("[TB] FAIL mis_store: got port=%0d err=%b rdata=%h at %0d want port=0 err=1 rdata=0 at 1",
                         p, err0, rdata0, c);
            else n_pass++;
        end
        req0 = 1'b0;
        step();
        n_checks++;
        if (rd_cycles - rd0 + wr_cycles - wr0 !== 0)
            $display("[TB] FAIL mis_strobes: got %0d want 0", rd_cycles - rd0 + wr_cycles - wr0);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int acks;
        mem[8] = 32'hCAFEF00D;
        ref_mem[8] = 32'hCAFEF00D;
        drive(1, 1'b1, 32'h20, 32'h12345678);
        step();
        n_checks++;
        if (mem_write !== 1'b1) $display("[TB] FAIL abort_pre: got mem_write=%b want 1", mem_write);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_write, mem_read, mem_addr} !== 34'h0)
            $display("[TB] FAIL abort_async: got wr=%b rd=%b addr=%h want 0 0 0", mem_write, mem_read, mem_addr);
        else n_pass++;
        req1 = 1'b0;
        acks = 0;
        step();
        if (ack0 | ack1) acks++;
        step();
        if (ack0 | ack1) acks++;
        reset = 1'b0;
        model_last = 1'b1;
        model_rd[0] = '0;
        model_rd[1] = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ack0 | ack1) acks++;
        end
        n_checks++;
        if (acks !== 0) $display("[TB] FAIL abort_noack: got %0d acks want 0", acks);
        else n_pass++;
        n_checks++;
        if (mem[8] !== 32'hCAFEF00D) $display("[TB] FAIL abort_mem: got %h want cafef00d", mem[8]);
        else n_pass++;
        n_checks++;
        if ({err0, err1, rdata0, rdata1, mem_wdata, cpu_stall} !== 99'h0)
            $display("[TB] FAIL abort_outputs: got err=%b%b rdata=%h %h wdata=%h stall=%b want all 0",
                     err0, err1, rdata0, rdata1, mem_wdata, cpu_stall);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL sb_leftover: got %0d want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hA5000000 | i;
            ref_mem[i] = 32'hA5000000 | i;
        end
        mem[0] = 32'h5;
        ref_mem[0] = 32'h5;
        test_reset();
        test_single_load();
        test_store_then_load();
        test_arbitration();
        test_misaligned();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
